avl_data_ram_responder: RTL and testbench

- Avalon-MM slave data memory answering the CPU's load/store bus (address, read, write, writedata, byteenable, waitrequest, readdata).
- Sits on the far side of the CPU data port. It receives the effective addresses and lane-aligned store data produced by the CPU datapath, and returns whole words for loads.
- Inserts a configurable number of wait states, applies byte-lane writes, and flags bus protocol violations.
- Used in CPU integration benches and as the on-chip data RAM.

---
 rtl/avl_data_ram_responder.sv | 137 +++++++++++++
 tb/tb_avl_data_ram_responder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/avl_data_ram_responder.sv
// Avalon-MM slave data RAM: byte-lane stores, whole-word loads, sticky protocol-error flag.
// Latency: WAIT_STATES waitrequest cycles, then one completion cycle (combinational readdata).
// Backpressure: waitrequest_o holds the master; a dropped request aborts the access and flags an error.
module avl_data_ram_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic [31:0] address_i,
  input  logic        read_i,
  input  logic        write_i,
  input  logic [31:0] writedata_i,
  input  logic [3:0]  byteenable_i,
  output logic        waitrequest_o,
  output logic [31:0] readdata_o,
  output logic        protocol_err_o
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0]  WS_M1 = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [31:0]     mem_q [DEPTH];

  logic            req;
  logic [31:0]     addr_off;
  logic [31:0]     off_hi;
  logic            in_range;
  logic            addr_ok;
  logic            legal;
  logic [ADDR_WIDTH-1:0] idx;
  logic            wait_req;
  logic            complete_raw;
  logic            complete;

  // Address decode: word index relative to BASE_ADDR and legality of the access.
  always_comb begin
    req      = read_i | write_i;
    addr_off = address_i - BASE_ADDR;
    off_hi   = addr_off >> (ADDR_WIDTH + 2);
    in_range = (address_i >= BASE_ADDR) && (off_hi == 32'd0);
    addr_ok  = in_range && (address_i[1:0] == 2'b00);
    idx      = addr_off[ADDR_WIDTH+1:2];
    legal    = addr_ok && !(read_i && write_i);
  end

  // Next-state logic: wait-state sequencing, completion strobe and sticky error.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wait_req     = 1'b0;
    complete_raw = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            complete_raw = 1'b1;
          end else if (WAIT_STATES == 1) begin
            wait_req = 1'b1;
            state_d  = S_DONE;
          end else begin
            wait_req = 1'b1;
            cnt_d    = WS_M1;
            state_d  = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_d = S_IDLE;
        end else begin
          wait_req = 1'b1;
          cnt_d    = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d      = S_IDLE;
        complete_raw = req;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abandoned accesses and illegal requests both latch the error until reset.
    err_d = err_q
          | (req && !addr_ok)
          | (read_i && write_i)
          | ((state_q != S_IDLE) && !req);
  end

  // Outputs are forced quiet while reset is held, even with a request pending.
  always_comb begin
    complete      = complete_raw & reset_i;
    waitrequest_o = wait_req & reset_i;
    readdata_o    = (complete && read_i && legal) ? mem_q[idx] : 32'h0;
    protocol_err_o = err_q;
  end

  // Control registers: FSM state, wait counter, sticky error.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Storage: byte-lane write at the end of a legal completion cycle; contents survive reset.
  always_ff @(posedge clk) begin
    if (complete && write_i && legal) begin
      for (int k = 0; k < 4; k++) begin
        if (byteenable_i[k]) begin
          mem_q[idx][8*k +: 8] <= writedata_i[8*k +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_avl_data_ram_responder.sv
// Bench for avl_data_ram_responder: three instances (2, 0 and 3 wait states) against a word-array model.
// Latency: each access is checked for exactly WAIT_STATES waitrequest cycles before completion.
// Backpressure: bench holds requests while waitrequest is high; every wait loop is cycle-bounded.
module tb_avl_data_ram_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b1;
  logic [31:0] addr [3];
  logic [31:0] wdat [3];
  logic [31:0] rdat [3];
  logic [3:0]  be   [3];
  logic        rd   [3];
  logic        wr   [3];
  logic        wreq [3];
  logic        perr [3];

  int n_assert = 0;
  int n_fail   = 0;

  // Reference memory: one 1024-word array per instance.
  logic [31:0] model [3][1024];

  avl_data_ram_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(2)) u_ws2 (
    .clk(clk), .reset_i(rst_n), .address_i(addr[0]), .read_i(rd[0]), .write_i(wr[0]),
    .writedata_i(wdat[0]), .byteenable_i(be[0]), .waitrequest_o(wreq[0]),
    .readdata_o(rdat[0]), .protocol_err_o(perr[0]));

  avl_data_ram_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset_i(rst_n), .address_i(addr[1]), .read_i(rd[1]), .write_i(wr[1]),
    .writedata_i(wdat[1]), .byteenable_i(be[1]), .waitrequest_o(wreq[1]),
    .readdata_o(rdat[1]), .protocol_err_o(perr[1]));

  avl_data_ram_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .reset_i(rst_n), .address_i(addr[2]), .read_i(rd[2]), .write_i(wr[2]),
    .writedata_i(wdat[2]), .byteenable_i(be[2]), .waitrequest_o(wreq[2]),
    .readdata_o(rdat[2]), .protocol_err_o(perr[2]));

  function automatic int ws_of(input int i);
    if (i == 0) return 2;
    if (i == 1) return 0;
    return 3;
  endfunction

  function automatic bit legal_addr(input logic [31:0] a);
    return (a >= 32'h1000) && ((a - 32'h1000) < 32'd4096) && ((a % 4) == 0);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - 32'h1000) / 4);
  endfunction

  function automatic logic [31:0] model_read(input int i, input logic [31:0] a);
    if (!legal_addr(a)) return 32'h0;
    return model[i][widx(a)];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bus access: hold the request while waitrequest is high, capture readdata at completion.
  task automatic access(input int i, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b,
                        output logic [31:0] rdata, output int nwait);
    @(negedge clk);
    addr[i] = a; wdat[i] = d; be[i] = b; rd[i] = r; wr[i] = w;
    nwait = 0;
    #1;
    while (wreq[i] === 1'b1 && nwait < 40) begin
      check("rdata_zero_while_waiting", rdat[i], 32'h0);
      nwait++;
      @(negedge clk);
      #1;
    end
    rdata = rdat[i];
    @(posedge clk);
    #1;
    rd[i] = 1'b0; wr[i] = 1'b0;
    if (w && !r && legal_addr(a)) begin
      for (int k = 0; k < 4; k++) begin
        if (b[k]) model[i][widx(a)][8*k +: 8] = d[8*k +: 8];
      end
    end
  endtask

  task automatic wr_chk(input int i, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, input string tag);
    logic [31:0] rdata;
    int nwait;
    access(i, 1'b0, 1'b1, a, d, b, rdata, nwait);
    check({tag, "_waits"}, 32'(nwait), 32'(ws_of(i)));
  endtask

  task automatic rd_chk(input int i, input logic [31:0] a, input logic [31:0] exp,
                        input string tag);
    logic [31:0] rdata;
    int nwait;
    access(i, 1'b1, 1'b0, a, 32'h0, 4'h0, rdata, nwait);
    check({tag, "_waits"}, 32'(nwait), 32'(ws_of(i)));
    check({tag, "_data"}, rdata, exp);
  endtask

  function automatic logic [31:0] pool_addr(input int w);
    return (w == 15) ? 32'h0000_1FFC : (32'h0000_1000 + 32'(4 * w));
  endfunction

  initial begin
    logic [31:0] rdata;
    int          nwait;
    logic [31:0] d;
    int          w;

    for (int i = 0; i < 3; i++) begin
      addr[i] = 32'h0; wdat[i] = 32'h0; be[i] = 4'h0; rd[i] = 1'b0; wr[i] = 1'b0;
    end

    // Reset state.
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("reset_waitrequest", 32'(wreq[i]), 32'h0);
      check("reset_readdata", rdat[i], 32'h0);
      check("reset_err", 32'(perr[i]), 32'h0);
    end
    rst_n = 1'b1;

    // Full-word write then read, two wait states.
    wr_chk(0, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF, "wr_1004");
    rd_chk(0, 32'h0000_1004, 32'hDEAD_BEEF, "rd_1004");
    @(negedge clk); #1;
    check("rdata_idle_after_read", rdat[0], 32'h0);

    // Byte-lane writes.
    wr_chk(0, 32'h0000_1008, 32'h1122_3344, 4'hF, "wr_1008_full");
    wr_chk(0, 32'h0000_1008, 32'hAABB_CCDD, 4'b0100, "wr_1008_lane2");
    rd_chk(0, 32'h0000_1008, 32'h11BB_3344, "rd_1008_a");
    wr_chk(0, 32'h0000_1008, 32'h0000_EEFF, 4'b0011, "wr_1008_lane10");
    rd_chk(0, 32'h0000_1008, 32'h11BB_EEFF, "rd_1008_b");

    // Zero wait states, read right behind the write.
    wr_chk(1, 32'h0000_1000, 32'h0000_0005, 4'hF, "ws0_wr");
    rd_chk(1, 32'h0000_1000, 32'h0000_0005, "ws0_rd");

    // Randomized legal traffic on every instance, model-checked.
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 16; k++) wr_chk(i, pool_addr(k), $urandom, 4'hF, "init_wr");
      for (int n = 0; n < 30; n++) begin
        w = int'($urandom_range(0, 15));
        if ($urandom_range(0, 1) == 1) begin
          d = $urandom;
          wr_chk(i, pool_addr(w), d, 4'($urandom_range(0, 15)), "rand_wr");
        end else begin
          rd_chk(i, pool_addr(w), model_read(i, pool_addr(w)), "rand_rd");
        end
      end
      check("no_err_after_legal_traffic", 32'(perr[i]), 32'h0);
    end

    // Illegal addresses and read+write: normal timing, no effect, sticky error.
    access(0, 1'b0, 1'b1, 32'h0000_0FFC, 32'hBAD0_BAD0, 4'hF, rdata, nwait);
    check("oor_wr_waits", 32'(nwait), 32'd2);
    check("oor_wr_err", 32'(perr[0]), 32'h1);
    rd_chk(0, 32'h0000_1002, 32'h0, "misaligned_rd");
    rd_chk(0, 32'h0000_1FFC, model_read(0, 32'h0000_1FFC), "top_word_intact");
    rd_chk(0, 32'h0000_1000, model_read(0, 32'h0000_1000), "word0_intact");
    access(0, 1'b1, 1'b1, 32'h0000_1004, 32'h0, 4'hF, rdata, nwait);
    check("rdwr_waits", 32'(nwait), 32'd2);
    check("rdwr_rdata", rdata, 32'h0);
    rd_chk(0, 32'h0000_1004, model_read(0, 32'h0000_1004), "rdwr_no_write");
    check("err_sticky", 32'(perr[0]), 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("err_cleared_by_reset", 32'(perr[0]), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Request dropped during WAIT on the three-wait-state instance.
    @(negedge clk);
    addr[2] = 32'h0000_1010; rd[2] = 1'b1;
    #1;
    check("drop_wreq_first", 32'(wreq[2]), 32'h1);
    @(negedge clk);
    #1;
    check("drop_wreq_in_wait", 32'(wreq[2]), 32'h1);
    rd[2] = 1'b0;
    #1;
    check("drop_wreq_released", 32'(wreq[2]), 32'h0);
    @(posedge clk);
    #1;
    check("drop_err", 32'(perr[2]), 32'h1);
    rd_chk(2, 32'h0000_1010, model_read(2, 32'h0000_1010), "after_drop_rd");

    // Async reset in the middle of a pending write.
    wr_chk(0, 32'h0000_100C, 32'hCAFE_F00D, 4'hF, "pre_reset_wr");
    @(negedge clk);
    addr[0] = 32'h0000_100C; wdat[0] = 32'h1234_5678; be[0] = 4'hF; wr[0] = 1'b1;
    #1;
    check("rst_mid_wreq_a", 32'(wreq[0]), 32'h1);
    @(posedge clk);
    #1;
    check("rst_mid_wreq_b", 32'(wreq[0]), 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_wreq_async", 32'(wreq[0]), 32'h0);
    @(negedge clk);
    wr[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rd_chk(0, 32'h0000_100C, 32'hCAFE_F00D, "rst_mid_no_write");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
